// File: rtl/decoder_scan_ctrl.sv
// Channel scan sequencer for a 4-to-16 enabled decoder: steps the select lines
// through 0..last, holding each channel enabled for a dwell time with an optional e-low gap.
module decoder_scan_ctrl #(
  parameter int DW    = 8,
  parameter int BLANK = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          cont,
  input  logic [DW-1:0] dwell,
  input  logic [3:0]    last,
  output logic          x,
  output logic          y,
  output logic          z,
  output logic          w,
  output logic          e,
  output logic          busy,
  output logic          done,
  output logic [3:0]    idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic          HAS_GAP  = (BLANK > 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]    GAP_LAST = (BLANK > 0) ? 4'(BLANK - 1) : 4'd0;
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [DW-1:0] r_dcnt;
  logic [3:0]    r_gcnt;
  logic [DW-1:0] r_dwell;
  logic [3:0]    r_last;
  logic          r_cont;
  logic          r_e;
  logic          r_busy;
  logic          r_done;

  state_t        w_state_nxt;
  logic [3:0]    w_idx_nxt;
  logic [DW-1:0] w_dcnt_nxt;
  logic [3:0]    w_gcnt_nxt;
  logic [DW-1:0] w_dwell_nxt;
  logic [3:0]    w_last_nxt;
  logic          w_cont_nxt;
  logic          w_dcnt_end;
  logic          w_gap_end;
  logic          w_at_last;
  logic          w_final;
  logic [3:0]    w_idx_inc;

  // r_dwell is at least 1 whenever ACTIVE, so the subtraction never wraps there
  assign w_dcnt_end = (r_dcnt == (r_dwell - ONE));
  assign w_gap_end  = (r_gcnt == GAP_LAST);
  assign w_at_last  = (r_idx == r_last);
  assign w_final    = w_at_last & ~r_cont;
  assign w_idx_inc  = w_at_last ? 4'd0 : (r_idx + 4'd1);

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_dcnt  <= {DW{1'b0}};
      r_gcnt  <= 4'd0;
      r_dwell <= {DW{1'b0}};
      r_last  <= 4'd0;
      r_cont  <= 1'b0;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= (w_state_nxt == S_IDLE) ? 4'd0 : w_idx_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_dwell <= w_dwell_nxt;
      r_last  <= w_last_nxt;
      r_cont  <= w_cont_nxt;
      r_e     <= (w_state_nxt == S_ACTIVE);
      r_busy  <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_GAP);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state selection; stop overrides everything outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) w_state_nxt = S_ACTIVE;
        else                w_state_nxt = S_IDLE;
      end
      S_ACTIVE: begin
        if (stop)            w_state_nxt = S_IDLE;
        else if (!w_dcnt_end) w_state_nxt = S_ACTIVE;
        else if (w_final)    w_state_nxt = S_DONE;
        else if (HAS_GAP)    w_state_nxt = S_GAP;
        else                 w_state_nxt = S_ACTIVE;
      end
      S_GAP: begin
        if (stop)           w_state_nxt = S_IDLE;
        else if (w_gap_end) w_state_nxt = S_ACTIVE;
        else                w_state_nxt = S_GAP;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counter, index and configuration updates; index advances on leaving ACTIVE so selects lead e
  always_comb begin
    w_idx_nxt   = r_idx;
    w_dcnt_nxt  = r_dcnt;
    w_gcnt_nxt  = r_gcnt;
    w_dwell_nxt = r_dwell;
    w_last_nxt  = r_last;
    w_cont_nxt  = r_cont;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_dwell_nxt = (dwell == {DW{1'b0}}) ? ONE : dwell;
          w_last_nxt  = last;
          w_cont_nxt  = cont;
          w_dcnt_nxt  = {DW{1'b0}};
          w_gcnt_nxt  = 4'd0;
          w_idx_nxt   = 4'd0;
        end else begin
          w_idx_nxt = 4'd0;
        end
      end
      S_ACTIVE: begin
        if (w_dcnt_end) begin
          w_dcnt_nxt = {DW{1'b0}};
          w_gcnt_nxt = 4'd0;
          w_idx_nxt  = w_final ? r_idx : w_idx_inc;
        end else begin
          w_dcnt_nxt = r_dcnt + ONE;
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          w_gcnt_nxt = 4'd0;
          w_dcnt_nxt = {DW{1'b0}};
        end else begin
          w_gcnt_nxt = r_gcnt + 4'd1;
        end
      end
      S_DONE:  w_idx_nxt = 4'd0;
      default: w_idx_nxt = 4'd0;
    endcase
  end

  assign x    = r_idx[3];
  assign y    = r_idx[2];
  assign z    = r_idx[1];
  assign w    = r_idx[0];
  assign idx  = r_idx;
  assign e    = r_e;
  assign busy = r_busy;
  assign done = r_done;

endmodule
